// File: rtl/phy_tx_serializer_if.sv
// Frame-load handshake and serial output bundle for the 4-lane transmit serializer.
// The master drives the lane bytes and requests; the slave (serializer) returns ready/out/active.
interface phy_tx_serializer_if;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic [3:0] valid_in;
    logic       in_load;
    logic       retrain;
    logic       in_ready;
    logic       out;
    logic       active;

    modport master (
        output in0, in1, in2, in3, valid_in, in_load, retrain,
        input  in_ready, out, active
    );

    modport slave (
        input  in0, in1, in2, in3, valid_in, in_load, retrain,
        output in_ready, out, active
    );
endinterface

// File: rtl/phy_tx_serializer.sv
// Bit-clock serializer: COM training after reset, then 4-byte frames MSB first in lane order,
// with IDLE filling every invalid slot. A one-frame hold buffer decouples loads from the wire.
module phy_tx_serializer #(
    parameter int         COM_COUNT = 4,
    parameter logic [7:0] COM_BYTE  = 8'hBC,
    parameter logic [7:0] IDLE_BYTE = 8'h7C
) (
    input  logic                clk32f,
    input  logic                reset,
    phy_tx_serializer_if.slave  link
);
    localparam int NUM_LANES = 4;
    localparam int CW        = $clog2(COM_COUNT + 1);
    localparam logic [CW-1:0] COM_LAST = CW'(COM_COUNT);

    typedef enum logic {TRAIN = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      bit_cnt_q, bit_cnt_d;
    logic [1:0]                      slot_q, slot_d;
    logic [CW-1:0]                   com_cnt_q, com_cnt_d;
    logic [7:0]                      shift_q, shift_d;
    logic                            out_q, out_d;
    logic                            active_q, active_d;
    logic                            in_ready_q, in_ready_d;
    logic                            retrain_pend_q, retrain_pend_d;
    logic                            hold_full_q, hold_full_d;
    logic [NUM_LANES-1:0][7:0]       hold_data_q, hold_data_d;
    logic [NUM_LANES-1:0]            hold_vld_q, hold_vld_d;
    logic [NUM_LANES-1:0][7:0]       fbuf_data_q, fbuf_data_d;
    logic [NUM_LANES-1:0]            fbuf_vld_q, fbuf_vld_d;

    logic [NUM_LANES-1:0][7:0]       lane_in;
    logic                            fs;
    logic                            load_acc;
    logic [7:0]                      sel_byte;

    assign lane_in  = {link.in3, link.in2, link.in1, link.in0};
    assign fs       = (bit_cnt_q == 3'd0) && (slot_q == 2'd0);
    assign load_acc = link.in_load && in_ready_q;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q + 3'd1;
        slot_d         = (bit_cnt_q == 3'd7) ? slot_q + 2'd1 : slot_q;
        com_cnt_d      = com_cnt_q;
        shift_d        = {shift_q[6:0], 1'b0};
        out_d          = shift_q[7];
        retrain_pend_d = retrain_pend_q;
        hold_full_d    = hold_full_q;
        hold_data_d    = hold_data_q;
        hold_vld_d     = hold_vld_q;
        fbuf_data_d    = fbuf_data_q;
        fbuf_vld_d     = fbuf_vld_q;
        sel_byte       = COM_BYTE;

        if (state_q == ACTIVE && link.retrain)
            retrain_pend_d = 1'b1;

        if (load_acc) begin
            hold_data_d = lane_in;
            hold_vld_d  = link.valid_in;
            hold_full_d = 1'b1;
        end

        if (fs) begin
            if (state_q == TRAIN) begin
                if (com_cnt_q == COM_LAST) begin
                    state_d   = ACTIVE;
                    com_cnt_d = '0;
                end
            end else if (retrain_pend_q) begin
                state_d        = TRAIN;
                retrain_pend_d = 1'b0;
            end

            // A load can only be accepted here when the hold was empty, so the
            // hold hand-off and a same-edge capture never collide.
            if (state_d == ACTIVE) begin
                if (hold_full_q) begin
                    fbuf_data_d = hold_data_q;
                    fbuf_vld_d  = hold_vld_q;
                    hold_full_d = 1'b0;
                end else begin
                    fbuf_vld_d  = '0;
                end
            end else begin
                fbuf_vld_d  = '0;
                hold_full_d = 1'b0;
                hold_vld_d  = '0;
            end
        end

        if (bit_cnt_q == 3'd0) begin
            if (state_d == TRAIN) begin
                sel_byte  = COM_BYTE;
                com_cnt_d = com_cnt_d + CW'(1);
            end else begin
                sel_byte  = fbuf_vld_d[slot_q] ? fbuf_data_d[slot_q] : IDLE_BYTE;
            end
            out_d   = sel_byte[7];
            shift_d = {sel_byte[6:0], 1'b0};
        end

        active_d   = (state_d == ACTIVE);
        in_ready_d = (state_d == ACTIVE) && !hold_full_d;
    end

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_q        <= TRAIN;
            bit_cnt_q      <= '0;
            slot_q         <= '0;
            com_cnt_q      <= '0;
            shift_q        <= '0;
            out_q          <= 1'b0;
            active_q       <= 1'b0;
            in_ready_q     <= 1'b0;
            retrain_pend_q <= 1'b0;
            hold_full_q    <= 1'b0;
            hold_data_q    <= '0;
            hold_vld_q     <= '0;
            fbuf_data_q    <= '0;
            fbuf_vld_q     <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            slot_q         <= slot_d;
            com_cnt_q      <= com_cnt_d;
            shift_q        <= shift_d;
            out_q          <= out_d;
            active_q       <= active_d;
            in_ready_q     <= in_ready_d;
            retrain_pend_q <= retrain_pend_d;
            hold_full_q    <= hold_full_d;
            hold_data_q    <= hold_data_d;
            hold_vld_q     <= hold_vld_d;
            fbuf_data_q    <= fbuf_data_d;
            fbuf_vld_q     <= fbuf_vld_d;
        end
    end

    assign link.out      = out_q;
    assign link.active   = active_q;
    assign link.in_ready = in_ready_q;
endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench: frame-level vector table plus hand sequences for load timing, retrain and reset.
module tb_phy_tx_serializer;
    logic clk32f = 1'b0;
    logic reset  = 1'b1;

    phy_tx_serializer_if link();

    phy_tx_serializer #(.COM_COUNT(4), .COM_BYTE(8'hBC), .IDLE_BYTE(8'h7C)) dut (
        .clk32f (clk32f),
        .reset  (reset),
        .link   (link)
    );

    always #5 clk32f = ~clk32f;

    typedef struct packed {
        logic [31:0] data;   // {in0,in1,in2,in3}
        logic [3:0]  vld;
        logic [31:0] exp;    // frame bytes, slot 0 in MSBs
    } vec_t;

    int tests = 0;
    int fails = 0;
    int edge_n;
    int ld_edge, ld2_edge, rt_edge;
    logic [31:0] ld_data, ld2_data;
    logic [3:0]  ld_vld, ld2_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive scheduled stimulus for the coming edge, take the edge, then settle.
    task automatic tick();
        logic [31:0] d;
        logic [3:0]  v;
        d = ld_data;
        v = ld_vld;
        if (edge_n + 1 == ld2_edge) begin
            d = ld2_data;
            v = ld2_vld;
        end
        link.in_load  = (edge_n + 1 == ld_edge) || (edge_n + 1 == ld2_edge);
        link.in0      = d[31:24];
        link.in1      = d[23:16];
        link.in2      = d[15:8];
        link.in3      = d[7:0];
        link.valid_in = v;
        link.retrain  = (edge_n + 1 == rt_edge);
        @(posedge clk32f);
        edge_n++;
        #1;
    endtask

    task automatic get_frame(output logic [31:0] f, output logic a_fs, output logic r_fs,
                             output logic r_mid);
        f = '0;
        a_fs = 1'b0;
        r_fs = 1'b0;
        r_mid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            f = {f[30:0], link.out};
            if (i == 0) begin
                a_fs = link.active;
                r_fs = link.in_ready;
            end
            if (i == 8) r_mid = link.in_ready;
        end
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        ld_edge       = -100;
        ld2_edge      = -100;
        rt_edge       = -100;
        ld_data       = '0;
        ld2_data      = '0;
        ld_vld        = '0;
        ld2_vld       = '0;
        link.in_load  = 1'b0;
        link.retrain  = 1'b0;
        link.in0      = '0;
        link.in1      = '0;
        link.in2      = '0;
        link.in3      = '0;
        link.valid_in = '0;
        repeat (2) @(posedge clk32f);
        @(negedge clk32f);
        reset  = 1'b0;
        edge_n = -1;
    endtask

    vec_t vecs[4];
    logic [31:0] f;
    logic a_fs, r_fs, r_mid;

    initial begin
        vecs[0] = '{data: 32'hA53CFF00, vld: 4'b1111, exp: 32'hA53CFF00};
        vecs[1] = '{data: 32'h11992255, vld: 4'b0101, exp: 32'h117C227C};
        vecs[2] = '{data: 32'hDEADBEEF, vld: 4'b0000, exp: 32'h7C7C7C7C};
        vecs[3] = '{data: 32'h01807EC3, vld: 4'b1010, exp: 32'h7C807CC3};

        edge_n = -1;
        ld_edge = -100; ld2_edge = -100; rt_edge = -100;
        ld_data = '0; ld2_data = '0; ld_vld = '0; ld2_vld = '0;
        link.in_load = 1'b0; link.retrain = 1'b0; link.valid_in = '0;
        link.in0 = '0; link.in1 = '0; link.in2 = '0; link.in3 = '0;
        repeat (2) @(posedge clk32f);
        #1;
        chk("reset_outputs", {29'd0, link.out, link.active, link.in_ready}, 32'd0);

        for (int vi = 0; vi < 4; vi++) begin
            reset_dut();
            ld_edge = 40;
            ld_data = vecs[vi].data;
            ld_vld  = vecs[vi].vld;
            get_frame(f, a_fs, r_fs, r_mid);
            chk($sformatf("v%0d_train_frame", vi), f, 32'hBCBCBCBC);
            chk($sformatf("v%0d_train_active", vi), {31'd0, a_fs}, 32'd0);
            chk($sformatf("v%0d_train_ready", vi), {31'd0, r_fs | r_mid}, 32'd0);
            get_frame(f, a_fs, r_fs, r_mid);
            chk($sformatf("v%0d_idle_frame", vi), f, 32'h7C7C7C7C);
            chk($sformatf("v%0d_e32_active_ready", vi), {30'd0, a_fs, r_fs}, 32'd3);
            chk($sformatf("v%0d_e40_ready", vi), {31'd0, r_mid}, 32'd0);
            get_frame(f, a_fs, r_fs, r_mid);
            chk($sformatf("v%0d_data_frame", vi), f, vecs[vi].exp);
            chk($sformatf("v%0d_e64_ready", vi), {31'd0, r_fs}, 32'd1);
        end

        // Second load while hold is full must be ignored.
        reset_dut();
        ld_edge = 40;  ld_data = 32'hA53CFF00;  ld_vld = 4'b1111;
        ld2_edge = 45; ld2_data = 32'h12345678; ld2_vld = 4'b1111;
        get_frame(f, a_fs, r_fs, r_mid);
        get_frame(f, a_fs, r_fs, r_mid);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("second_load_ignored", f, 32'hA53CFF00);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("after_hold_idle", f, 32'h7C7C7C7C);

        // Load exactly on the frame-start edge goes to hold, no bypass.
        reset_dut();
        ld_edge = 64; ld_data = 32'hC0FFEE42; ld_vld = 4'b1111;
        get_frame(f, a_fs, r_fs, r_mid);
        get_frame(f, a_fs, r_fs, r_mid);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("fs_load_frame_idle", f, 32'h7C7C7C7C);
        chk("fs_load_ready_e64", {31'd0, r_fs}, 32'd0);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("fs_load_frame_next", f, 32'hC0FFEE42);
        chk("fs_load_ready_e96", {31'd0, r_fs}, 32'd1);

        // Retrain mid-frame: frame completes, COM frame follows, pending hold dropped.
        reset_dut();
        ld_edge = 40;  ld_data = 32'hA53CFF00;  ld_vld = 4'b1111;
        ld2_edge = 72; ld2_data = 32'h55AA55AA; ld2_vld = 4'b1111;
        rt_edge = 70;
        get_frame(f, a_fs, r_fs, r_mid);
        get_frame(f, a_fs, r_fs, r_mid);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("rt_inflight_frame", f, 32'hA53CFF00);
        chk("rt_e72_load_taken", {31'd0, r_mid}, 32'd0);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("rt_com_frame", f, 32'hBCBCBCBC);
        chk("rt_e96_active_ready", {30'd0, a_fs, r_fs}, 32'd0);
        get_frame(f, a_fs, r_fs, r_mid);
        chk("rt_hold_discarded", f, 32'h7C7C7C7C);
        chk("rt_e128_active_ready", {30'd0, a_fs, r_fs}, 32'd3);

        // Asynchronous reset in the middle of an IDLE byte.
        reset_dut();
        get_frame(f, a_fs, r_fs, r_mid);
        repeat (6) tick();
        chk("pre_reset_out_active", {30'd0, link.out, link.active}, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out_active", {30'd0, link.out, link.active}, 32'd0);
        reset_dut();
        get_frame(f, a_fs, r_fs, r_mid);
        chk("post_reset_train", f, 32'hBCBCBCBC);
        chk("post_reset_active", {31'd0, a_fs}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
